// File: rtl/uart_apb_host.sv
// APB master that initialises a UART (busy-wait on USR, then DLAB/divisor/LCR writes)
// and then polls LSR to move bytes. RX path is built only with UART_APB_HOST_RX_EN.
module uart_apb_host #(
  parameter int unsigned POLL_GAP = 4
) (
  input  logic        sys_clk,
  input  logic        rst_b,
  input  logic        cfg_start,
  input  logic [15:0] cfg_divisor,
  input  logic [4:0]  cfg_lcr,
  output logic        cfg_done,
  input  logic        tx_vld,
  input  logic [7:0]  tx_data,
  output logic        tx_rdy,
  output logic        rx_vld,
  output logic [7:0]  rx_data,
  output logic [2:0]  rx_err,
  output logic        host_apb_psel,
  output logic        host_apb_penable,
  output logic        host_apb_pwrite,
  output logic [7:0]  host_apb_paddr,
  output logic [31:0] host_apb_pwdata,
  input  logic [31:0] host_apb_prdata,
  output logic        busy
);

  localparam int unsigned GAP_W  = 8;
  localparam int unsigned BYTE_W = 8;
  localparam logic [7:0] ADDR_DATA = 8'h00;
  localparam logic [7:0] ADDR_DLH  = 8'h04;
  localparam logic [7:0] ADDR_LCR  = 8'h0C;
  localparam logic [7:0] ADDR_LSR  = 8'h14;
  localparam logic [7:0] ADDR_USR  = 8'h7C;

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_USR_RD      = 4'd1,
    S_LCR_DLAB_WR = 4'd2,
    S_DLL_WR      = 4'd3,
    S_DLH_WR      = 4'd4,
    S_LCR_WR      = 4'd5,
    S_GAP         = 4'd6,
    S_LSR_RD      = 4'd7,
    S_DECIDE      = 4'd8,
`ifdef UART_APB_HOST_RX_EN
    S_RBR_RD      = 4'd9,
`endif
    S_THR_WR      = 4'd10
  } state_t;

  state_t             r_state, w_nxt_state;
  logic               r_phase, w_nxt_phase;
  logic [GAP_W-1:0]   r_gap_cnt, w_nxt_gap_cnt;
  logic [15:0]        r_div;
  logic [4:0]         r_lcr;
  logic               r_cfg_done;
  logic               r_lsr_thre;
  logic [BYTE_W-1:0]  r_tx_data;
  logic               w_bus_state;
  logic               w_idle_gap;
  logic               w_cfg_go;
  logic               w_access_end;
  logic               w_rx_go;
  logic               w_tx_go;
  logic               w_unused_prdata;

  // r_phase: 0 = SETUP, 1 = ACCESS within every bus state
  assign w_bus_state  = !(r_state inside {S_IDLE, S_GAP, S_DECIDE});
  assign w_idle_gap   = (r_state inside {S_IDLE, S_GAP});
  assign w_cfg_go     = cfg_start && w_idle_gap;
  assign w_access_end = w_bus_state && r_phase;
  assign w_tx_go      = (r_state == S_DECIDE) && !w_rx_go && r_lsr_thre && tx_vld;
  assign cfg_done     = r_cfg_done;
  assign w_unused_prdata = ^host_apb_prdata;

  // State register
  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state   <= S_IDLE;
      r_phase   <= 1'b0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_nxt_state;
      r_phase   <= w_nxt_phase;
      r_gap_cnt <= w_nxt_gap_cnt;
    end
  end

  // Next-state logic
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_phase   = 1'b0;
    w_nxt_gap_cnt = '0;
    if (w_bus_state && !r_phase) begin
      w_nxt_phase = 1'b1;
    end else begin
      case (r_state)
        S_IDLE:        if (cfg_start) w_nxt_state = S_USR_RD;
        S_USR_RD:      w_nxt_state = host_apb_prdata[0] ? S_GAP : S_LCR_DLAB_WR;
        S_LCR_DLAB_WR: w_nxt_state = S_DLL_WR;
        S_DLL_WR:      w_nxt_state = S_DLH_WR;
        S_DLH_WR:      w_nxt_state = S_LCR_WR;
        S_LCR_WR:      w_nxt_state = S_GAP;
        S_GAP: begin
          if (cfg_start) begin
            w_nxt_state = S_USR_RD;
          end else if (r_gap_cnt == GAP_W'(POLL_GAP - 1)) begin
            w_nxt_state = r_cfg_done ? S_LSR_RD : S_USR_RD;
          end else begin
            w_nxt_gap_cnt = r_gap_cnt + GAP_W'(1);
          end
        end
        S_LSR_RD:      w_nxt_state = S_DECIDE;
        S_DECIDE: begin
          if (w_rx_go) begin
`ifdef UART_APB_HOST_RX_EN
            w_nxt_state = S_RBR_RD;
`endif
          end else if (w_tx_go) begin
            w_nxt_state = S_THR_WR;
          end else begin
            w_nxt_state = S_GAP;
          end
        end
`ifdef UART_APB_HOST_RX_EN
        S_RBR_RD:      w_nxt_state = S_GAP;
`endif
        S_THR_WR:      w_nxt_state = S_GAP;
        default:       w_nxt_state = S_IDLE;
      endcase
    end
  end

  // Output decode: APB fields are a pure function of registered state and captured data
  always_comb begin
    host_apb_psel    = w_bus_state;
    host_apb_penable = w_bus_state && r_phase;
    host_apb_pwrite  = 1'b0;
    host_apb_paddr   = '0;
    host_apb_pwdata  = '0;
    tx_rdy           = w_tx_go;
    busy             = !w_idle_gap;
    case (r_state)
      S_USR_RD: host_apb_paddr = ADDR_USR;
      S_LCR_DLAB_WR: begin
        host_apb_pwrite = 1'b1;
        host_apb_paddr  = ADDR_LCR;
        host_apb_pwdata = {24'd0, 8'h80 | {3'b000, r_lcr}};
      end
      S_DLL_WR: begin
        host_apb_pwrite = 1'b1;
        host_apb_paddr  = ADDR_DATA;
        host_apb_pwdata = {24'd0, r_div[7:0]};
      end
      S_DLH_WR: begin
        host_apb_pwrite = 1'b1;
        host_apb_paddr  = ADDR_DLH;
        host_apb_pwdata = {24'd0, r_div[15:8]};
      end
      S_LCR_WR: begin
        host_apb_pwrite = 1'b1;
        host_apb_paddr  = ADDR_LCR;
        host_apb_pwdata = {24'd0, 3'b000, r_lcr};
      end
      S_LSR_RD: host_apb_paddr = ADDR_LSR;
      S_THR_WR: begin
        host_apb_pwrite = 1'b1;
        host_apb_paddr  = ADDR_DATA;
        host_apb_pwdata = {24'd0, r_tx_data};
      end
      default: ;
    endcase
  end

  // Configuration capture, LSR snapshot and TX byte holding
  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b) begin
      r_div      <= '0;
      r_lcr      <= '0;
      r_cfg_done <= 1'b0;
      r_lsr_thre <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      if (w_cfg_go) begin
        r_div      <= cfg_divisor;
        r_lcr      <= cfg_lcr;
        r_cfg_done <= 1'b0;
      end else if (r_state == S_LCR_WR && w_access_end) begin
        r_cfg_done <= 1'b1;
      end
      if (r_state == S_LSR_RD && w_access_end) r_lsr_thre <= host_apb_prdata[5];
      if (w_tx_go) r_tx_data <= tx_data;
    end
  end

`ifdef UART_APB_HOST_RX_EN
  logic              r_lsr_dr;
  logic [2:0]        r_lsr_err;
  logic              r_rx_vld;
  logic [BYTE_W-1:0] r_rx_data;
  logic [2:0]        r_rx_err;

  assign w_rx_go = (r_state == S_DECIDE) && r_lsr_dr;
  assign rx_vld  = r_rx_vld;
  assign rx_data = r_rx_data;
  assign rx_err  = r_rx_err;

  // rx_err carries {fe, pe, oe} from the LSR read that preceded this RBR read
  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b) begin
      r_lsr_dr  <= 1'b0;
      r_lsr_err <= '0;
      r_rx_vld  <= 1'b0;
      r_rx_data <= '0;
      r_rx_err  <= '0;
    end else begin
      r_rx_vld <= (r_state == S_RBR_RD) && w_access_end;
      if (r_state == S_LSR_RD && w_access_end) begin
        r_lsr_dr  <= host_apb_prdata[0];
        r_lsr_err <= host_apb_prdata[3:1];
      end
      if (r_state == S_RBR_RD && w_access_end) begin
        r_rx_data <= host_apb_prdata[7:0];
        r_rx_err  <= r_lsr_err;
      end
    end
  end
`else
  assign w_rx_go = 1'b0;
  assign rx_vld  = 1'b0;
  assign rx_data = '0;
  assign rx_err  = '0;
`endif

endmodule

// File: doc/uart_apb_host.md
UART_APB_HOST -- requirements
Module: uart_apb_host

Interface
REQ-001 SHALL have parameter POLL_GAP, default 4, meaning the number of idle cycles (1..255) between successive LSR polls.
REQ-002 SHALL have port sys_clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_b, input, 1; reset rst_b, asynchronous, active-low; clock sys_clk.
REQ-004 SHALL have port cfg_start, input, 1, a one-cycle pulse requesting UART initialisation.
REQ-005 SHALL have port cfg_divisor, input, 16, the baud divisor, with DLH = [15:8] and DLL = [7:0].
REQ-006 SHALL have port cfg_lcr, input, 5, the LCR[4:0] value {eps, pen, stop, dls[1:0]}.
REQ-007 SHALL have port cfg_done, output, 1, high once initialisation has completed.
REQ-008 SHALL have ports tx_vld (input, 1), tx_data (input, 8) and tx_rdy (output, 1), forming a transmit byte stream.
REQ-009 SHALL have ports rx_vld (output, 1), rx_data (output, 8) and rx_err (output, 3, {fe, pe, oe}), forming a receive byte stream.
REQ-010 SHALL have ports host_apb_psel, host_apb_penable and host_apb_pwrite (outputs, 1), host_apb_paddr (output, 8) and host_apb_pwdata (output, 32).
REQ-011 SHALL have port host_apb_prdata, input, 32, the APB read data.
REQ-012 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE or GAP.

Function
REQ-013 SHALL use the following UART byte addresses: RBR/THR/DLL 0x00, DLH 0x04, LCR 0x0C, LSR 0x14, USR 0x7C.
REQ-014 SHALL perform every APB transfer as one SETUP cycle (psel=1, penable=0) followed by one ACCESS cycle (psel=1, penable=1), with no pready and no wait states.
REQ-015 SHALL hold paddr, pwrite and pwdata stable across both phases of a transfer, and SHALL drive pwdata[31:8]=0.
REQ-016 SHALL sample prdata[7:0] only in the ACCESS cycle of a read.
REQ-017 SHALL implement the states IDLE, USR_RD, LCR_DLAB_WR, DLL_WR, DLH_WR, LCR_WR, GAP, LSR_RD, DECIDE, RBR_RD and THR_WR.
REQ-018 SHALL go from IDLE or GAP to USR_RD on cfg_start, capturing cfg_divisor and cfg_lcr and clearing cfg_done; cfg_start in any other state SHALL be ignored.
REQ-019 SHALL repeat USR_RD, with one GAP of POLL_GAP cycles between reads, until USR[0]=0, because divisor writes are dropped while the UART is busy.
REQ-020 SHALL then write LCR=0x80|cfg_lcr, DLL, DLH and LCR=cfg_lcr in that order, set cfg_done=1 and enter GAP.
REQ-021 SHALL, in GAP, count POLL_GAP cycles when cfg_done=1 and then go to LSR_RD, which captures LSR[7:0].
REQ-022 SHALL, in DECIDE (one cycle), go to RBR_RD if LSR[0]=1; otherwise, if LSR[5]=1 and tx_vld=1, go to THR_WR; otherwise go to GAP. RX SHALL have priority over TX.
REQ-023 SHALL assert tx_rdy combinationally only in DECIDE when the THR_WR branch is taken, capture tx_data in that cycle, and write it in THR_WR.
REQ-024 SHALL, in RBR_RD, output rx_data=prdata[7:0] and rx_err=LSR[3:1] captured by the preceding LSR_RD, with a one-cycle rx_vld pulse in the cycle after ACCESS; there is no backpressure.
REQ-025 SHALL return to GAP after both RBR_RD and THR_WR.
REQ-026 SHALL remain in IDLE with tx_rdy=0 and no polling until cfg_done=1.

Reset
REQ-027 SHALL, while rst_b=0, force the FSM to IDLE and drive all outputs to 0, including paddr, pwdata, rx_data, rx_err and cfg_done.
REQ-028 SHALL, on an assertion of rst_b during a transfer, deassert psel/penable immediately, and SHALL not resume the transfer after reset.

Configuration
REQ-029 SHALL include the RX path (RBR_RD state, rx_vld/rx_data/rx_err) when macro UART_APB_HOST_RX_EN is defined.
REQ-030 SHALL, without UART_APB_HOST_RX_EN, ignore LSR[0] in DECIDE, omit the RBR_RD state, and tie rx_vld, rx_data and rx_err to 0; the ports SHALL remain present.

Verification
REQ-031 SHALL cover: cfg_start with divisor 0x0145 and lcr 0x03, USR=0 -> APB writes (0x0C,0x83),(0x00,0x45),(0x04,0x01),(0x0C,0x03), then cfg_done=1.
REQ-032 SHALL cover: USR reads 1,1,0 -> three USR reads separated by 4-cycle gaps, then the same write sequence.
REQ-033 SHALL cover: LSR=0x60 with tx_vld=1 and tx_data=0x5A -> one tx_rdy pulse and a write of (0x00,0x5A).
REQ-034 SHALL cover, with RX_EN: LSR=0x63, RBR=0xA7 and tx_vld=1 -> an RBR read, rx_vld pulse with rx_data=0xA7 and rx_err=3'b001, and no THR write in that poll.
REQ-035 SHALL cover: rst_b low during the DLL_WR ACCESS cycle -> psel=0 at once; after release FSM in IDLE, cfg_done=0 and no bus activity.
REQ-036 SHALL cover: cfg_start during THR_WR -> ignored; a later cfg_start in GAP restarts initialisation.
